// File: rtl/div.sv
// ----------------------------------------------------------------------------
// div : multi-cycle 32-bit integer divider (signed DIV / unsigned DIVU)
//
// Restoring shift-subtract divider, one quotient bit per cycle. The EX stage
// holds start_i high until it has consumed the result; dropping start_i
// returns the block to FREE, ready for the next operation.
//
// Ports
//   clk          : clock, rising-edge active
//   rst          : synchronous active-high reset
//   signed_div_i : 1 = signed division, 0 = unsigned
//   opdata1_i    : dividend
//   opdata2_i    : divisor
//   start_i      : request, held until the result is consumed
//   annul_i      : abort the in-flight operation
//   result_o     : {remainder, quotient}, 64'h0 unless ready_o
//   ready_o      : result_o valid this cycle
// ----------------------------------------------------------------------------
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [31:0] rem;      // partial remainder
    logic [31:0] quo;      // dividend bits shifting out, quotient bits shifting in
    logic [31:0] divisor;
    logic        neg_q;    // negate quotient at the end
    logic        neg_r;    // negate remainder at the end

    logic [31:0] a_abs, b_abs;
    logic [32:0] shifted;
    logic [31:0] diff;
    logic        borrow;
    logic [31:0] rem_nxt, quo_nxt;
    logic [31:0] q_fin, r_fin;

    always_comb begin
        a_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
        b_abs = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

        shifted = {rem, quo[31]};
        // 33-bit compare against the divisor: if the shifted-out top bit is
        // set the value certainly exceeds the divisor and the true difference
        // fits in 32 bits, so a 32-bit subtract is sufficient.
        borrow  = ~shifted[32] && (shifted[31:0] < divisor);
        diff    = shifted[31:0] - divisor;
        rem_nxt = borrow ? shifted[31:0] : diff;
        quo_nxt = {quo[30:0], ~borrow};

        q_fin = neg_q ? (~quo_nxt + 32'd1) : quo_nxt;
        r_fin = neg_r ? (~rem_nxt + 32'd1) : rem_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                    if (start_i && !annul_i) begin
                        cnt     <= '0;
                        rem     <= '0;
                        quo     <= a_abs;
                        divisor <= b_abs;
                        neg_q   <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                        neg_r   <= signed_div_i && opdata1_i[31];
                        state   <= (opdata2_i == 32'd0) ? BYZERO : ON;
                    end
                end

                BYZERO: begin
                    if (annul_i) begin
                        state <= FREE;
                    end else begin
                        state    <= END;
                        result_o <= '0;
                        ready_o  <= 1'b1;
                    end
                end

                ON: begin
                    if (annul_i) begin
                        state <= FREE;
                        cnt   <= '0;
                    end else begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            state    <= END;
                            result_o <= {r_fin, q_fin};
                            ready_o  <= 1'b1;
                        end
                    end
                end

                END: begin
                    if (!start_i) begin
                        state    <= FREE;
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end

                default: state <= FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// ----------------------------------------------------------------------------
// tb_div : directed, table-driven bench for div
// ----------------------------------------------------------------------------
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks   = 0;
    int failures = 0;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        string       name;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Launch one operation and follow it through END and back to FREE.
    // Edges are counted from the accepting edge (n=1); ready in cycle 34
    // means it is first seen after edge 33.
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit scramble, input string name);
        int lat;
        int exp_lat;
        lat     = 0;
        exp_lat = (b == 32'd0) ? 2 : 33;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n == 1 && scramble) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~sgn;
            end
            if (ready_o) begin
                lat = n;
                break;
            end
        end
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " result"}, result_o, exp);
        @(posedge clk);
        #1;
        check({name, " hold"}, {ready_o, result_o[62:0]} ^ {1'b0, result_o[63], 62'd0},
              {1'b1, exp[62:0]} ^ {1'b0, exp[63], 62'd0});
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({name, " release"}, {63'd0, ready_o} | result_o, 64'd0);
    endtask

    initial begin
        vec_t vecs[11];
        int   lat;
        bit   seen;

        vecs[0]  = '{1'b0, 32'd7,        32'd2,        64'h00000001_00000003, "u7/2"};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, "s-7/2"};
        vecs[2]  = '{1'b0, 32'hFFFFFFF9, 32'd2,        64'h00000001_7FFFFFFC, "uFFFFFFF9/2"};
        vecs[3]  = '{1'b0, 32'd100,      32'd0,        64'h0,                 "u100/0"};
        vecs[4]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, "sMIN/-1"};
        vecs[5]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, "s7/-2"};
        vecs[6]  = '{1'b0, 32'd1000,     32'd3,        64'h00000001_0000014D, "u1000/3"};
        vecs[7]  = '{1'b0, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF, "uMAX/1"};
        vecs[8]  = '{1'b0, 32'd5,        32'd7,        64'h00000005_00000000, "u5/7"};
        vecs[9]  = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, "s-100/-7"};
        vecs[10] = '{1'b1, 32'hFFFFFFF9, 32'd0,        64'h0,                 "s-7/0"};

        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", {63'd0, ready_o} | result_o, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++)
            run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, (i % 2) == 1, vecs[i].name);

        // Annul after 10 iterations of 1000/3.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        check("annul next", {63'd0, ready_o} | result_o, 64'd0);
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (ready_o) seen = 1'b1;
        end
        check("annul no ready", 64'(seen), 64'd0);
        run_op(1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D, 1'b0, "after annul 1000/3");

        // annul_i blocks acceptance in FREE; no effect in END.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd7;
        opdata2_i    = 32'd2;
        start_i      = 1'b1;
        annul_i      = 1'b1;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        lat     = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (ready_o) begin
                lat = n;
                break;
            end
        end
        check("annul in FREE latency", 64'(lat), 64'd33);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        check("annul in END ready", 64'(ready_o), 64'd1);
        check("annul in END result", result_o, 64'h00000001_00000003);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("annul in END release", {63'd0, ready_o} | result_o, 64'd0);

        // Reset at iteration 20, then a clean 9/4 with operands scrambled.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        start_i = 1'b0;
        check("mid-ON reset", {63'd0, ready_o} | result_o, 64'd0);
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (ready_o) seen = 1'b1;
        end
        check("reset no ready", 64'(seen), 64'd0);
        run_op(1'b0, 32'd9, 32'd4, 64'h00000001_00000002, 1'b1, "u9/4 scrambled");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
